// File: rtl/iiitb_vm_pkg.sv
// Shared codes, denominations and state encoding for the vending controller.
package iiitb_vm_pkg;

  localparam logic [1:0] COIN_NONE = 2'd0;
  localparam logic [1:0] COIN_5    = 2'd1;
  localparam logic [1:0] COIN_10   = 2'd2;
  localparam logic [1:0] COIN_BAD  = 2'd3;

  localparam logic [1:0] ITEM_A = 2'd1;
  localparam logic [1:0] ITEM_B = 2'd2;

  localparam int unsigned DENOM_5  = 5;
  localparam int unsigned DENOM_10 = 10;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StVend,
    StChange
  } state_e;

endpackage

// File: rtl/iiitb_vm_timeout.sv
// Idle-cycle counter; expired flags the TIMEOUT-th consecutive enabled cycle.
module iiitb_vm_timeout #(
  parameter int unsigned TIMEOUT = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign expired = en && (r_cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/iiitb_vm_ctrl.sv
// Purchase sequencer: coin collection, priced selection, dispense handshake and
// coin-by-coin change return.
module iiitb_vm_ctrl
  import iiitb_vm_pkg::*;
#(
  parameter int unsigned PRICE_A  = 15,
  parameter int unsigned PRICE_B  = 20,
  parameter int unsigned TIMEOUT  = 100,
  parameter int unsigned CREDIT_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          in,
  input  logic [1:0]          sel,
  input  logic                sel_valid,
  input  logic                cancel,
  input  logic                disp_ready,
  output logic                disp_valid,
  output logic [1:0]          disp_item,
  input  logic                chg_ready,
  output logic                chg_valid,
  output logic [1:0]          chg_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                reject,
  output logic                busy
);

  localparam int unsigned CMAX = ((2 ** CREDIT_W - 1) / 5) * 5;
  localparam int unsigned SW   = CREDIT_W + 1;

  state_e                r_state, w_state_d;
  logic [CREDIT_W-1:0]   r_credit, w_credit_d;
  logic [1:0]            r_disp_item, w_disp_item_d;
  logic                  r_reject, w_reject_d;

  logic [CREDIT_W-1:0]   w_coin_val, w_price, w_chg_val;
  logic                  w_coin_present, w_coin_good, w_coin_fits, w_sel_ok;
  logic                  w_to_en, w_to_clr, w_to_expired;

  always_comb begin
    w_coin_val = '0;
    if (in == COIN_5)  w_coin_val = CREDIT_W'(DENOM_5);
    if (in == COIN_10) w_coin_val = CREDIT_W'(DENOM_10);
  end

  assign w_coin_present = (in != COIN_NONE);
  assign w_coin_good    = (in == COIN_5) || (in == COIN_10);
  assign w_coin_fits    = ({1'b0, r_credit} + {1'b0, w_coin_val}) <= SW'(CMAX);
  assign w_price        = (sel == ITEM_A) ? CREDIT_W'(PRICE_A) : CREDIT_W'(PRICE_B);
  assign w_sel_ok       = sel_valid && ((sel == ITEM_A) || (sel == ITEM_B)) &&
                          (r_credit >= w_price);
  // Largest coin that never overdraws credit (credit is always a multiple of 5).
  assign w_chg_val      = (r_credit >= CREDIT_W'(DENOM_10)) ? CREDIT_W'(DENOM_10)
                                                             : CREDIT_W'(DENOM_5);

  assign w_to_en  = (r_state == StCollect) && !w_coin_present && !sel_valid && !cancel;
  assign w_to_clr = !w_to_en;

  iiitb_vm_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .en     (w_to_en),
    .clr    (w_to_clr),
    .expired(w_to_expired)
  );

  always_comb begin
    w_state_d     = r_state;
    w_credit_d    = r_credit;
    w_disp_item_d = r_disp_item;
    w_reject_d    = (in == COIN_BAD);
    unique case (r_state)
      StIdle: begin
        if (w_coin_good) begin
          if (w_coin_fits) begin
            w_credit_d = r_credit + w_coin_val;
            w_state_d  = StCollect;
          end else begin
            w_reject_d = 1'b1;
          end
        end
      end
      StCollect: begin
        if (cancel) begin
          w_reject_d = w_coin_present;
          w_state_d  = StChange;
        end else if (w_coin_present) begin
          if (w_coin_good && w_coin_fits) begin
            w_credit_d = r_credit + w_coin_val;
          end else begin
            w_reject_d = 1'b1;
          end
        end else if (w_sel_ok) begin
          w_credit_d    = r_credit - w_price;
          w_disp_item_d = sel;
          w_state_d     = StVend;
        end else if (w_to_expired) begin
          w_state_d = StChange;
        end
      end
      StVend: begin
        w_reject_d = w_coin_present;
        if (disp_ready) begin
          w_state_d = (r_credit == '0) ? StIdle : StChange;
        end
      end
      StChange: begin
        w_reject_d = w_coin_present;
        if (chg_ready) begin
          w_credit_d = r_credit - w_chg_val;
          if (r_credit == w_chg_val) w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_credit    <= '0;
      r_disp_item <= COIN_NONE;
      r_reject    <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_credit    <= w_credit_d;
      r_disp_item <= w_disp_item_d;
      r_reject    <= w_reject_d;
    end
  end

  assign disp_valid = (r_state == StVend);
  assign disp_item  = r_disp_item;
  assign chg_valid  = (r_state == StChange);
  assign chg_coin   = !chg_valid ? COIN_NONE :
                      (r_credit >= CREDIT_W'(DENOM_10)) ? COIN_10 : COIN_5;
  assign credit     = r_credit;
  assign reject     = r_reject;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_iiitb_vm_ctrl.sv
// Scoreboard bench: a behavioural purchase model predicts credit, rejects and the
// expected dispense/change streams; a negedge monitor compares against the DUT.
module tb_iiitb_vm_ctrl;

  localparam int PA = 15;
  localparam int PB = 20;
  localparam int TO = 100;
  localparam int CW = 6;
  localparam int CMAX_TB = (2 ** CW - 1) - ((2 ** CW - 1) % 5);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    in = 2'd0, sel = 2'd0;
  logic          sel_valid = 1'b0, cancel = 1'b0, disp_ready = 1'b0, chg_ready = 1'b0;
  logic          disp_valid, chg_valid, reject, busy;
  logic [1:0]    disp_item, chg_coin;
  logic [CW-1:0] credit;

  always #5 clk = ~clk;

  iiitb_vm_ctrl #(
    .PRICE_A (PA),
    .PRICE_B (PB),
    .TIMEOUT (TO),
    .CREDIT_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .sel       (sel),
    .sel_valid (sel_valid),
    .cancel    (cancel),
    .disp_ready(disp_ready),
    .disp_valid(disp_valid),
    .disp_item (disp_item),
    .chg_ready (chg_ready),
    .chg_valid (chg_valid),
    .chg_coin  (chg_coin),
    .credit    (credit),
    .reject    (reject),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: 0 idle, 1 collecting, 2 vending, 3 paying change.
  int mode = 0, m_credit = 0, m_idle = 0, m_item = 0;
  bit m_rej = 0, m_live = 0, m_rst_last = 0;
  int disp_q[$];
  int chg_q[$];

  function automatic void push_change(input int amount);
    int c = amount;
    while (c >= 10) begin
      chg_q.push_back(2);
      c -= 10;
    end
    if (c > 0) chg_q.push_back(1);
  endfunction

  always @(posedge clk) begin : model
    int v, price;
    bit act;
    if (rst) begin
      mode = 0; m_credit = 0; m_idle = 0; m_item = 0; m_rej = 0;
      m_live = 1; m_rst_last = 1;
      disp_q.delete();
      chg_q.delete();
    end else begin
      m_rst_last = 0;
      v = (in == 2'd1) ? 5 : (in == 2'd2) ? 10 : 0;
      m_rej = (in == 2'd3);
      act = (in != 2'd0) || sel_valid || cancel;
      case (mode)
        0: if (v > 0) begin
          if (m_credit + v <= CMAX_TB) begin
            m_credit += v;
            mode = 1;
          end else m_rej = 1;
        end
        1: begin
          price = (sel == 2'd1) ? PA : PB;
          if (cancel) begin
            m_rej = (in != 2'd0);
            mode = 3;
            push_change(m_credit);
          end else if (in != 2'd0) begin
            if (v > 0 && m_credit + v <= CMAX_TB) m_credit += v;
            else m_rej = 1;
          end else if (sel_valid) begin
            if ((sel == 2'd1 || sel == 2'd2) && m_credit >= price) begin
              m_credit -= price;
              m_item = sel;
              mode = 2;
              disp_q.push_back(sel);
            end
          end else if (m_idle == TO - 1) begin
            mode = 3;
            push_change(m_credit);
          end
        end
        2: begin
          m_rej = (in != 2'd0);
          if (disp_ready) begin
            if (m_credit == 0) mode = 0;
            else begin
              mode = 3;
              push_change(m_credit);
            end
          end
        end
        default: begin
          m_rej = (in != 2'd0);
          if (chg_ready) begin
            m_credit -= (m_credit >= 10) ? 10 : 5;
            if (m_credit == 0) mode = 0;
          end
        end
      endcase
      m_idle = (mode == 1 && !act) ? m_idle + 1 : 0;
    end
  end

  always @(negedge clk) begin : monitor
    if (m_live) begin
      check("credit", credit, m_credit);
      check("busy", busy, mode != 0);
      check("disp_valid", disp_valid, mode == 2);
      check("chg_valid", chg_valid, mode == 3);
      check("reject", reject, m_rej);
      if (mode == 2) check("disp_item_hold", disp_item, m_item);
      if (m_rst_last) begin
        check("rst_disp_item", disp_item, 0);
        check("rst_chg_coin", chg_coin, 0);
      end
      if (!rst && disp_valid && disp_ready)
        check("disp_item_xfer", disp_item, disp_q.size() > 0 ? disp_q.pop_front() : -1);
      if (!rst && chg_valid && chg_ready)
        check("chg_coin_xfer", chg_coin, chg_q.size() > 0 ? chg_q.pop_front() : -1);
    end
  end

  task automatic step(input logic [1:0] c, input logic [1:0] s, input logic sv, input logic cn,
                      input logic dr, input logic cr, input logic r);
    in = c; sel = s; sel_valid = sv; cancel = cn; disp_ready = dr; chg_ready = cr; rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input int n, input logic dr, input logic cr);
    for (int i = 0; i < n; i++) step(2'd0, 2'd0, 1'b0, 1'b0, dr, cr, 1'b0);
  endtask

  initial begin
    step(2'd0, 2'd0, 0, 0, 0, 0, 1);
    step(2'd0, 2'd0, 0, 0, 0, 0, 1);
    // 10+10, buy A, one five back.
    step(2'd2, 2'd0, 0, 0, 0, 0, 0);
    step(2'd2, 2'd0, 0, 0, 0, 0, 0);
    step(2'd0, 2'd1, 1, 0, 0, 0, 0);
    quiet(1, 1'b0, 1'b0);
    quiet(1, 1'b1, 1'b0);
    quiet(3, 1'b0, 1'b1);
    // 5+10, B too expensive, then cancel.
    step(2'd1, 2'd0, 0, 0, 0, 0, 0);
    step(2'd2, 2'd0, 0, 0, 0, 0, 0);
    step(2'd0, 2'd2, 1, 0, 0, 0, 0);
    quiet(2, 1'b0, 1'b0);
    step(2'd0, 2'd0, 0, 1, 0, 0, 0);
    quiet(4, 1'b0, 1'b1);
    // Bad coin in idle; coin during vend.
    step(2'd3, 2'd0, 0, 0, 0, 0, 0);
    quiet(2, 1'b0, 1'b0);
    step(2'd2, 2'd0, 0, 0, 0, 0, 0);
    step(2'd2, 2'd0, 0, 0, 0, 0, 0);
    step(2'd0, 2'd1, 1, 0, 0, 0, 0);
    step(2'd2, 2'd0, 0, 0, 0, 0, 0);
    quiet(1, 1'b1, 1'b0);
    quiet(3, 1'b0, 1'b1);
    // Idle timeout refund.
    step(2'd2, 2'd0, 0, 0, 0, 0, 0);
    quiet(TO + 2, 1'b0, 1'b0);
    quiet(3, 1'b0, 1'b1);
    // Stalled dispense, then reset mid-purchase.
    step(2'd2, 2'd0, 0, 0, 0, 0, 0);
    step(2'd2, 2'd0, 0, 0, 0, 0, 0);
    step(2'd0, 2'd2, 1, 0, 0, 0, 0);
    quiet(5, 1'b0, 1'b0);
    step(2'd0, 2'd0, 0, 0, 1, 1, 1);
    quiet(2, 1'b0, 1'b0);
    // Fill to CMAX, overflow coin, refund.
    for (int i = 0; i < 6; i++) step(2'd2, 2'd0, 0, 0, 0, 0, 0);
    step(2'd1, 2'd0, 0, 0, 0, 0, 0);
    quiet(1, 1'b0, 1'b0);
    step(2'd0, 2'd0, 0, 1, 0, 0, 0);
    quiet(8, 1'b0, 1'b1);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [1:0] c;
      c = ($urandom_range(0, 9) < 7) ? 2'd0 : 2'($urandom_range(1, 3));
      step(c, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 29) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 399) == 0);
    end
    step(2'd0, 2'd0, 0, 1, 1, 1, 0);
    quiet(20, 1'b1, 1'b1);
    check("disp_q_drained", disp_q.size(), 0);
    check("chg_q_drained", chg_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
